keystream_pack_buffer: RTL and testbench
========================================

# keystream_pack_buffer

Parametrised keystream byte buffer sitting between the ChaCha20 state serialiser and the XOR/Poly1305 datapath. Accepts serialised bytes over a valid/ready handshake, packs PACK consecutive bytes little-endian into one word, and stores up to DEPTH words in a circular FIFO drained through a second valid/ready handshake. Unlike the previous fixed single-shot capture buffer, it supports continuous streaming, wrap-around, backpressure on both sides, and message termination with partial final words.

## Interface
- DATA_SIZE, 8: bits per input byte lane.
- PACK, 4: byte lanes per output word (≥1).
- DEPTH, 80: word entries in the FIFO (≥2; need not be a power of two).
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  input byte present.
- in_data  in  DATA_SIZE  serialised keystream byte.
- in_last  in  1  byte is final of message; closes the current word.
- in_ready  out  1  buffer accepts a byte this cycle.
- out_valid  out  1  head word available.
- out_data  out  DATA_SIZE*PACK  head word; lane 0 = bits [DATA_SIZE-1:0] = first byte.
- out_keep  out  PACK  per-lane valid mask of head word.
- out_last  out  1  head word ends a message.
- out_ready  in  1  consumer takes head word this cycle.
- full  out  1  DEPTH words stored.
- empty  out  1  no words stored.
- level  out  $clog2(DEPTH+1)  words stored.

## Operation
- Byte accepted when in_valid && in_ready. in_ready = !full.
- Pack accumulator holds lanes 0..lane_idx-1 of the current word; lane_idx counts 0..PACK-1.
- On accepted byte: written into lane lane_idx. If lane_idx == PACK-1 or in_last: word (accumulator plus incoming byte) pushed to FIFO at wr_ptr, keep = lanes 0..lane_idx set, last = in_last; lane_idx returns to 0. Otherwise lane_idx increments.
- in_last with lane_idx == PACK-1 gives a full word with keep all ones and last = 1.
- Pop when out_valid && out_ready; rd_ptr advances.
- wr_ptr and rd_ptr wrap from DEPTH-1 to 0; level tracks push/pop: push only → +1, pop only → −1, both → unchanged.
- full = (level == DEPTH); empty = (level == 0); out_valid = !empty.
- Push and pop in the same cycle allowed whenever not full; when full, no push occurs regardless of out_ready (in_ready is registered-state based, no combinational path out_ready → in_ready).
- out_data/out_keep/out_last read the entry at rd_ptr; all zero while out_valid = 0.
- in_valid with in_ready = 0: byte not taken, accumulator unchanged; producer must hold data.
- out_valid, once asserted, stays asserted with stable data until popped.

## Timing
- Reset: in_ready 1, out_valid 0, out_data 0, out_keep 0, out_last 0, full 0, empty 1, level 0, lane_idx 0, pointers 0. Storage contents need not be cleared.
- rst mid-operation discards the accumulator and all stored words in one cycle; partial words are lost.
- Latency: word closed on edge N → out_valid, level, empty update after edge N (visible in cycle N+1).
- Pop on edge N → next entry presented in cycle N+1; full drops in cycle N+1.
- Sustained throughput: one byte in per cycle, one word out per cycle.

## Configuration
- KSBUF_ZERO_PAD_EN defined: lanes not set in out_keep of a partial word read as zero.
- Undefined: those lanes are don't-care (stale accumulator contents); consumers must qualify by out_keep.
- Full words identical in both builds.

## Test plan
- PACK=4: bytes 0x00..0x07, out_ready=1 → two words 0x03020100, 0x07060504, keep 0xF, last 0; level peaks at 1.
- Bytes 0xA1,0xA2,0xA3 with in_last on 0xA3 → one word, keep 0x7, last 1; with KSBUF_ZERO_PAD_EN out_data = 0x00A3A2A1.
- DEPTH=4, out_ready=0, stream 20 bytes → after 16 bytes full=1, in_ready=0, level=4; byte 17 held; release out_ready → words drain in order, byte 17 accepted the cycle after full drops.
- Continuous push/pop across 3×DEPTH words with random out_ready → no loss, order preserved across pointer wrap, level never exceeds DEPTH.
- Assert rst with 2 stored words and 3 lanes accumulated → next cycle level 0, empty 1, out_valid 0; following 4 bytes form a clean word starting at lane 0.
- in_last on the fourth byte of a word → keep 0xF, last 1, and the next byte starts lane 0 of a new word.

Source files
------------

// File: rtl/keystream_pack_buffer.sv
// Keystream byte buffer: packs PACK bytes little-endian per word into a DEPTH-entry circular FIFO.
// Build option: define KSBUF_ZERO_PAD_EN to zero the unkept lanes of partial words.
module keystream_pack_buffer #(
    parameter int unsigned DATA_SIZE = 8,
    parameter int unsigned PACK      = 4,
    parameter int unsigned DEPTH     = 80
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [DATA_SIZE-1:0]      in_data,
    input  logic                      in_last,
    output logic                      in_ready,
    output logic                      out_valid,
    output logic [DATA_SIZE*PACK-1:0] out_data,
    output logic [PACK-1:0]           out_keep,
    output logic                      out_last,
    input  logic                      out_ready,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int unsigned WordW = DATA_SIZE * PACK;
    localparam int unsigned PtrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LvlW  = $clog2(DEPTH + 1);
    localparam int unsigned LaneW = (PACK > 1) ? $clog2(PACK) : 1;

    localparam logic [PtrW-1:0]  PtrMax  = PtrW'(DEPTH - 1);
    localparam logic [LaneW-1:0] LaneMax = LaneW'(PACK - 1);
    localparam logic [LvlW-1:0]  LvlFull = LvlW'(DEPTH);

    logic [WordW-1:0] mem_data [DEPTH];
    logic [PACK-1:0]  mem_keep [DEPTH];
    logic             mem_last [DEPTH];

    logic [PACK-1:0][DATA_SIZE-1:0] acc_q;
    logic [LaneW-1:0]               lane_q;
    logic [PtrW-1:0]                wr_ptr_q;
    logic [PtrW-1:0]                rd_ptr_q;
    logic [LvlW-1:0]                level_q;

    logic                           accept;
    logic                           push;
    logic                           pop;
    logic [PACK-1:0][DATA_SIZE-1:0] word;
    logic [PACK-1:0]                keep;

    // in_ready depends only on stored level, never on out_ready.
    assign full      = (level_q == LvlFull);
    assign empty     = (level_q == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign level     = level_q;

    assign accept = in_valid && in_ready;
    assign push   = accept && (in_last || (lane_q == LaneMax));
    assign pop    = out_valid && out_ready;

    always_comb begin
        word = acc_q;
        keep = '0;
        for (int l = 0; l < PACK; l++) begin
            if (LaneW'(l) == lane_q) begin
                word[l] = in_data;
            end
`ifdef KSBUF_ZERO_PAD_EN
            else if (LaneW'(l) > lane_q) begin
                word[l] = '0;
            end
`endif
            keep[l] = (LaneW'(l) <= lane_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            lane_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (accept) begin
                acc_q[lane_q] <= in_data;
                lane_q        <= push ? '0 : lane_q + 1'b1;
            end
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == PtrMax) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PtrMax) ? '0 : rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage is intentionally left uncleared by reset; level gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr_q] <= word;
            mem_keep[wr_ptr_q] <= keep;
            mem_last[wr_ptr_q] <= in_last;
        end
    end

    assign out_data = out_valid ? mem_data[rd_ptr_q] : '0;
    assign out_keep = out_valid ? mem_keep[rd_ptr_q] : '0;
    assign out_last = out_valid && mem_last[rd_ptr_q];

endmodule

// File: tb/tb_keystream_pack_buffer.sv
// Randomised bench for keystream_pack_buffer (PACK=4, DEPTH=4) against a queue-based word model.
module tb_keystream_pack_buffer;

    localparam int unsigned DataSize = 8;
    localparam int unsigned Pack     = 4;
    localparam int unsigned Depth    = 4;
    localparam int unsigned WordW    = DataSize * Pack;
`ifdef KSBUF_ZERO_PAD_EN
    localparam bit ZeroPad = 1'b1;
`else
    localparam bit ZeroPad = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic [7:0]       in_data = '0;
    logic             in_last = 1'b0;
    logic             in_ready;
    logic             out_valid;
    logic [WordW-1:0] out_data;
    logic [Pack-1:0]  out_keep;
    logic             out_last;
    logic             out_ready = 1'b0;
    logic             full;
    logic             empty;
    logic [2:0]       level;

    always #5 clk = ~clk;

    keystream_pack_buffer #(
        .DATA_SIZE(DataSize),
        .PACK     (Pack),
        .DEPTH    (Depth)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_last  (in_last),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_keep (out_keep),
        .out_last (out_last),
        .out_ready(out_ready),
        .full     (full),
        .empty    (empty),
        .level    (level)
    );

    typedef struct packed {
        logic [WordW-1:0] data;
        logic [Pack-1:0]  keep;
        logic             last;
    } word_t;

    int         n_checks = 0;
    int         n_fails  = 0;
    int         peak_level;
    word_t      exp_q[$];
    logic [7:0] cur_bytes[$];
    logic [7:0] src_data[$];
    bit         src_last[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WordW-1:0] lane_mask(input logic [Pack-1:0] k);
        logic [WordW-1:0] m = '0;
        for (int i = 0; i < Pack; i++) if (k[i]) m[8*i +: 8] = 8'hFF;
        return m;
    endfunction

    // A word closes after Pack bytes or on a last byte; bytes land little-endian.
    task automatic model_byte(input logic [7:0] b, input bit last);
        word_t w;
        cur_bytes.push_back(b);
        if (cur_bytes.size() == Pack || last) begin
            w.data = '0;
            for (int i = 0; i < cur_bytes.size(); i++) w.data |= WordW'(cur_bytes[i]) << (8 * i);
            w.keep = Pack'((1 << cur_bytes.size()) - 1);
            w.last = last;
            exp_q.push_back(w);
            cur_bytes.delete();
        end
    endtask

    task automatic check_state();
        logic [WordW-1:0] m;
        int n = exp_q.size();
        check("level", 64'(level), 64'(n));
        check("empty", 64'(empty), 64'(n == 0));
        check("full", 64'(full), 64'(n == Depth));
        check("in_ready", 64'(in_ready), 64'(n < Depth));
        check("out_valid", 64'(out_valid), 64'(n != 0));
        if (n != 0) begin
            m = ZeroPad ? '1 : lane_mask(exp_q[0].keep);
            check("out_data", 64'(out_data & m), 64'(exp_q[0].data & m));
            check("out_keep", 64'(out_keep), 64'(exp_q[0].keep));
            check("out_last", 64'(out_last), 64'(exp_q[0].last));
        end else begin
            check("idle_data", 64'(out_data), 64'(0));
            check("idle_keep", 64'(out_keep), 64'(0));
            check("idle_last", 64'(out_last), 64'(0));
        end
        if (int'(level) > peak_level) peak_level = int'(level);
    endtask

    // Called just after a rising edge; drives, checks at negedge, then advances the model.
    task automatic cycle(input bit v, input logic [7:0] d, input bit l, input bit r,
                         output bit took);
        bit popped;
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = r;
        @(negedge clk);
        check_state();
        took   = v && (exp_q.size() < Depth);
        popped = r && (exp_q.size() != 0);
        @(posedge clk);
        #1;
        if (popped) void'(exp_q.pop_front());
        if (took) model_byte(d, l);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        cur_bytes.delete();
        @(negedge clk);
        check("rst_level", 64'(level), 64'(0));
        check("rst_empty", 64'(empty), 64'(1));
        check("rst_full", 64'(full), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_out_keep", 64'(out_keep), 64'(0));
        check("rst_out_last", 64'(out_last), 64'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic queue_bytes(input logic [7:0] first, input int n, input int last_at);
        for (int i = 0; i < n; i++) begin
            src_data.push_back(first + 8'(i));
            src_last.push_back(i == last_at);
        end
    endtask

    task automatic run_stream(input int valid_pct, input int ready_pct, input int budget);
        bit took;
        int cyc = 0;
        while (src_data.size() != 0 && cyc < budget) begin
            cycle($urandom_range(99) < valid_pct, src_data[0], src_last[0],
                  $urandom_range(99) < ready_pct, took);
            if (took) begin
                void'(src_data.pop_front());
                void'(src_last.pop_front());
            end
            cyc++;
        end
        if (src_data.size() != 0) begin
            check("stream_timeout", 64'(src_data.size()), 64'(0));
            src_data.delete();
            src_last.delete();
        end
    endtask

    task automatic drain(input int budget);
        bit took;
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < budget) begin
            cycle(1'b0, 8'h00, 1'b0, 1'b1, took);
            cyc++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'(0));
        cycle(1'b0, 8'h00, 1'b0, 1'b1, took);
    endtask

    initial begin
        bit took;
        do_reset();

        // Eight sequential bytes, consumer always ready: two full words, level never above 1.
        peak_level = 0;
        queue_bytes(8'h00, 8, -1);
        run_stream(100, 100, 100);
        drain(50);
        check("peak_level", 64'(peak_level), 64'(1));

        // Three-byte message closed by in_last.
        queue_bytes(8'hA1, 3, 2);
        run_stream(100, 100, 100);
        drain(50);

        // Fill to DEPTH with consumer stalled; the 17th byte must be held.
        queue_bytes(8'h10, 20, -1);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, src_data[0], src_last[0], 1'b0, took);
            if (took) begin
                void'(src_data.pop_front());
                void'(src_last.pop_front());
            end
        end
        in_valid  = 1'b1;
        in_data   = src_data[0];
        out_ready = 1'b0;
        @(negedge clk);
        check("stall_full", 64'(full), 64'(1));
        check("stall_in_ready", 64'(in_ready), 64'(0));
        check("stall_level", 64'(level), 64'(Depth));
        @(posedge clk);
        #1;
        run_stream(100, 100, 100);
        drain(50);

        // Mid-operation reset with two words stored and three lanes pending.
        queue_bytes(8'h40, 11, -1);
        run_stream(100, 0, 100);
        do_reset();
        queue_bytes(8'h50, 4, -1);
        run_stream(100, 100, 100);
        drain(50);

        // in_last on lane 3, then a fresh two-byte message.
        queue_bytes(8'h31, 4, 3);
        queue_bytes(8'h35, 2, 1);
        run_stream(100, 100, 100);
        drain(50);

        // Random traffic across several pointer wraps.
        for (int i = 0; i < 3 * Depth * Pack + 8; i++) begin
            src_data.push_back(8'($urandom));
            src_last.push_back($urandom_range(9) == 0);
        end
        run_stream(70, 50, 2000);
        drain(100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
